soml_frame_loader: RTL and testbench

Input sequencer directly upstream of the SOML decoder top. It accepts one complex-sample stream per frame over a valid/ready handshake and buffers a full frame: 16 channel coefficients H in row-major order, then 8 received samples Y. It then issues the decoder's start pulse and replays H and Y on the decoder's load interface with exact cycle alignment. A credit from the decoder's output_valid paces frames so that only one frame is in flight.

---
 rtl/soml_frame_loader_pkg.sv | 28 ++
 rtl/soml_frame_buffer.sv | 53 +++++
 rtl/soml_frame_loader.sv | 203 ++++++++++++++++++++
 tb/tb_soml_frame_loader.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soml_frame_loader_pkg.sv
// Shared definitions for the SOML frame loader.
// Holds the frame geometry (H/Y word counts), counter widths and the 3-bit
// loader state encoding used by soml_frame_loader and soml_frame_buffer.
package soml_frame_loader_pkg;

  localparam int unsigned H_WORDS   = 16;
  localparam int unsigned Y_WORDS   = 8;
  localparam int unsigned FRAME_LEN = H_WORDS + Y_WORDS;

  // wr_cnt addresses the whole frame, rd_cnt only the H half.
  localparam int unsigned WR_CNT_W = 5;
  localparam int unsigned RD_CNT_W = 4;

  localparam logic [2:0] ST_COLLECT = 3'd0;
  localparam logic [2:0] ST_DISCARD = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_ISSUE   = 3'd3;
  localparam logic [2:0] ST_STREAM  = 3'd4;

  typedef enum logic [2:0] {
    StCollect = ST_COLLECT,
    StDiscard = ST_DISCARD,
    StWait    = ST_WAIT,
    StIssue   = ST_ISSUE,
    StStream  = ST_STREAM
  } state_e;

endpackage

// File: rtl/soml_frame_buffer.sv
// Frame buffer for the SOML frame loader.
// FRAME_LEN x 2N register file: entries 0..H_WORDS-1 hold H, the remaining
// Y_WORDS entries hold Y. One synchronous write port, two asynchronous reads.
// Ports:
//   clk_i                  clock
//   we_i, waddr_i          write enable / frame word index
//   wdata_r_i, wdata_i_i   real/imag write data
//   h_idx_i                H read index (0..H_WORDS-1)
//   y_idx_i                Y read index (0..Y_WORDS-1)
//   h_r_o, h_i_o           H read data
//   y_r_o, y_i_o           Y read data
module soml_frame_buffer
  import soml_frame_loader_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [WR_CNT_W-1:0] waddr_i,
  input  logic [N-1:0]        wdata_r_i,
  input  logic [N-1:0]        wdata_i_i,
  input  logic [RD_CNT_W-1:0] h_idx_i,
  input  logic [2:0]          y_idx_i,
  output logic [N-1:0]        h_r_o,
  output logic [N-1:0]        h_i_o,
  output logic [N-1:0]        y_r_o,
  output logic [N-1:0]        y_i_o
);

  logic [N-1:0] mem_r [FRAME_LEN];
  logic [N-1:0] mem_i [FRAME_LEN];

  logic [WR_CNT_W-1:0] h_addr;
  logic [WR_CNT_W-1:0] y_addr;

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_r[waddr_i] <= wdata_r_i;
      mem_i[waddr_i] <= wdata_i_i;
    end
  end

  always_comb begin
    h_addr = {1'b0, h_idx_i};
    y_addr = WR_CNT_W'(H_WORDS) + {2'b00, y_idx_i};
    h_r_o  = mem_r[h_addr];
    h_i_o  = mem_i[h_addr];
    y_r_o  = mem_r[y_addr];
    y_i_o  = mem_i[y_addr];
  end

endmodule

// File: rtl/soml_frame_loader.sv
// SOML frame loader: buffers one 24-word frame (16 H then 8 Y) from a
// valid/ready stream, then pulses start and replays H/Y to the decoder with
// H valid for 16 cycles and Y valid for the first 8, starting the cycle after
// start. A one-bit credit returned by dec_done keeps one frame in flight.
// Ports:
//   clk, rst                      clock, async active-high reset
//   s_valid/s_ready/s_data_*/s_last  upstream sample stream
//   dec_done                      decoder output_valid, returns the credit
//   start                         one-cycle decoder start pulse
//   H_in_valid/H_in_r/H_in_i      H replay (zero when not valid)
//   Y_in_valid/Y_in_r/Y_in_i      Y replay (zero when not valid)
//   frame_err                     one-cycle pulse on a malformed frame
//   frames_issued                 wrapping count of streamed frames
module soml_frame_loader
  import soml_frame_loader_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_data_r,
  input  logic [N-1:0] s_data_i,
  input  logic         s_last,
  input  logic         dec_done,
  output logic         start,
  output logic         H_in_valid,
  output logic [N-1:0] H_in_r,
  output logic [N-1:0] H_in_i,
  output logic         Y_in_valid,
  output logic [N-1:0] Y_in_r,
  output logic [N-1:0] Y_in_i,
  output logic         frame_err,
  output logic [7:0]   frames_issued
);

  localparam logic [WR_CNT_W-1:0] LastWr = WR_CNT_W'(FRAME_LEN - 1);
  localparam logic [RD_CNT_W-1:0] LastRd = RD_CNT_W'(H_WORDS - 1);

  state_e              state_q, state_d;
  logic [WR_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic                credit_q, credit_d;
  logic                s_ready_q, s_ready_d;
  logic                start_q, start_d;
  logic                err_q, err_d;
  logic [7:0]          fi_q, fi_d;
  logic                h_valid_q, h_valid_d;
  logic                y_valid_q, y_valid_d;
  logic [N-1:0]        h_r_q, h_r_d, h_i_q, h_i_d;
  logic [N-1:0]        y_r_q, y_r_d, y_i_q, y_i_d;

  logic                xfer;
  logic                consume;
  logic                buf_we;
  logic [N-1:0]        buf_h_r, buf_h_i, buf_y_r, buf_y_i;

  // Read ports are addressed with the next rd_cnt so the registered outputs
  // carry entry rd_cnt in the cycle that rd_cnt holds that value.
  soml_frame_buffer #(
    .N (N)
  ) u_buf (
    .clk_i     (clk),
    .we_i      (buf_we),
    .waddr_i   (wr_cnt_q),
    .wdata_r_i (s_data_r),
    .wdata_i_i (s_data_i),
    .h_idx_i   (rd_cnt_d),
    .y_idx_i   (rd_cnt_d[2:0]),
    .h_r_o     (buf_h_r),
    .h_i_o     (buf_h_i),
    .y_r_o     (buf_y_r),
    .y_i_o     (buf_y_i)
  );

  // Next-state, counters and credit.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    fi_d     = fi_q;
    start_d  = 1'b0;
    err_d    = 1'b0;
    buf_we   = 1'b0;
    consume  = 1'b0;
    xfer     = s_valid & s_ready_q;

    case (state_q)
      StCollect: begin
        if (xfer) begin
          buf_we = 1'b1;
          if (wr_cnt_q == LastWr) begin
            wr_cnt_d = '0;
            if (s_last) begin
              state_d = StWait;
            end else begin
              err_d   = 1'b1;
              state_d = StDiscard;
            end
          end else if (s_last) begin
            err_d    = 1'b1;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      StDiscard: begin
        if (xfer && s_last) begin
          wr_cnt_d = '0;
          state_d  = StCollect;
        end
      end
      StWait: begin
        if (credit_q) begin
          consume = 1'b1;
          start_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        rd_cnt_d = '0;
        state_d  = StStream;
      end
      StStream: begin
        if (rd_cnt_q == LastRd) begin
          fi_d     = fi_q + 8'd1;
          wr_cnt_d = '0;
          state_d  = StCollect;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: state_d = StCollect;
    endcase

    // A return in the consuming cycle wins, and returns saturate at one.
    credit_d = credit_q;
    if (dec_done) begin
      credit_d = 1'b1;
    end else if (consume) begin
      credit_d = 1'b0;
    end
  end

  // Registered outputs follow the next state.
  always_comb begin
    s_ready_d = (state_d == StCollect) || (state_d == StDiscard);
    h_valid_d = (state_d == StStream);
    y_valid_d = h_valid_d && !rd_cnt_d[RD_CNT_W-1];
    h_r_d     = h_valid_d ? buf_h_r : '0;
    h_i_d     = h_valid_d ? buf_h_i : '0;
    y_r_d     = y_valid_d ? buf_y_r : '0;
    y_i_d     = y_valid_d ? buf_y_i : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StCollect;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      credit_q  <= 1'b1;
      s_ready_q <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      fi_q      <= '0;
      h_valid_q <= 1'b0;
      y_valid_q <= 1'b0;
      h_r_q     <= '0;
      h_i_q     <= '0;
      y_r_q     <= '0;
      y_i_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      credit_q  <= credit_d;
      s_ready_q <= s_ready_d;
      start_q   <= start_d;
      err_q     <= err_d;
      fi_q      <= fi_d;
      h_valid_q <= h_valid_d;
      y_valid_q <= y_valid_d;
      h_r_q     <= h_r_d;
      h_i_q     <= h_i_d;
      y_r_q     <= y_r_d;
      y_i_q     <= y_i_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign start         = start_q;
  assign frame_err     = err_q;
  assign frames_issued = fi_q;
  assign H_in_valid    = h_valid_q;
  assign H_in_r        = h_r_q;
  assign H_in_i        = h_i_q;
  assign Y_in_valid    = y_valid_q;
  assign Y_in_r        = y_r_q;
  assign Y_in_i        = y_i_q;

endmodule

// File: tb/tb_soml_frame_loader.sv
module tb_soml_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_last;
  logic [31:0] s_data_r, s_data_i;
  logic        dec_done, dd_man, dd_rand, dd_rand_en;
  logic        start, H_in_valid, Y_in_valid, frame_err;
  logic [31:0] H_in_r, H_in_i, Y_in_r, Y_in_i;
  logic [7:0]  frames_issued;

  assign dec_done = dd_man | dd_rand;

  soml_frame_loader #(
    .N (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data_r      (s_data_r),
    .s_data_i      (s_data_i),
    .s_last        (s_last),
    .dec_done      (dec_done),
    .start         (start),
    .H_in_valid    (H_in_valid),
    .H_in_r        (H_in_r),
    .H_in_i        (H_in_i),
    .Y_in_valid    (Y_in_valid),
    .Y_in_r        (Y_in_r),
    .Y_in_i        (Y_in_i),
    .frame_err     (frame_err),
    .frames_issued (frames_issued)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: frames in word order, parsed by the framing rules.
  typedef struct packed {
    logic [23:0][31:0] r;
    logic [23:0][31:0] i;
  } frame_t;

  frame_t exp_q[$];
  frame_t m_fr;
  int     m_cnt  = 0;
  bit     m_disc = 1'b0;
  int     m_err  = 0;

  task automatic model_accept(input logic [31:0] r, input logic [31:0] i, input bit last);
    if (m_disc) begin
      if (last) m_disc = 1'b0;
    end else begin
      m_fr.r[m_cnt] = r;
      m_fr.i[m_cnt] = i;
      m_cnt++;
      if (last) begin
        if (m_cnt == 24) exp_q.push_back(m_fr);
        else m_err++;
        m_cnt = 0;
      end else if (m_cnt == 24) begin
        m_err++;
        m_disc = 1'b1;
        m_cnt  = 0;
      end
    end
  endtask

  // Stream monitor: every start must match a modelled frame, and the replay
  // must follow it cycle for cycle.
  frame_t cur;
  bit     mon_active = 1'b0;
  bit     mon_fi_pend = 1'b0;
  int     mon_idx = 0;
  int     starts = 0;
  int     err_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_active  = 1'b0;
      mon_fi_pend = 1'b0;
      starts      = 0;
    end else begin
      if (mon_active) begin
        check("h_valid", 64'(H_in_valid), 64'd1);
        check("h_r", 64'(H_in_r), 64'(cur.r[mon_idx]));
        check("h_i", 64'(H_in_i), 64'(cur.i[mon_idx]));
        if (mon_idx < 8) begin
          check("y_valid", 64'(Y_in_valid), 64'd1);
          check("y_r", 64'(Y_in_r), 64'(cur.r[16+mon_idx]));
          check("y_i", 64'(Y_in_i), 64'(cur.i[16+mon_idx]));
        end else begin
          check("y_valid_low", 64'(Y_in_valid), 64'd0);
          check("y_zero", {Y_in_r, Y_in_i}, 64'd0);
        end
        mon_idx++;
        if (mon_idx == 16) begin
          mon_active  = 1'b0;
          mon_fi_pend = 1'b1;
        end
      end else if (mon_fi_pend) begin
        check("frames_issued", 64'(frames_issued), 64'(starts[7:0]));
        check("s_ready_back", 64'(s_ready), 64'd1);
        check("h_valid_end", 64'(H_in_valid), 64'd0);
        mon_fi_pend = 1'b0;
      end else begin
        check("idle_valids", {62'd0, H_in_valid, Y_in_valid}, 64'd0);
      end
      if (frame_err) err_seen++;
      if (start) begin
        check("start_ready_low", 64'(s_ready), 64'd0);
        check("start_has_frame", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          cur        = exp_q.pop_front();
          mon_active = 1'b1;
          mon_idx    = 0;
        end
        starts++;
      end
    end
  end

  always @(negedge clk) dd_rand = dd_rand_en && ($urandom_range(0, 3) == 0);

  task automatic finish_now(input string why);
    $display("FAIL %s at %0t", why, $time);
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $fatal(1, "aborted");
  endtask

  // Called and returns at a negedge.
  task automatic send_word(input logic [31:0] r, input logic [31:0] i, input bit last);
    bit rdy;
    s_valid  = 1'b1;
    s_data_r = r;
    s_data_i = i;
    s_last   = last;
    for (int w = 0; w < 1000; w++) begin
      rdy = s_ready;
      @(negedge clk);
      if (rdy) begin
        model_accept(r, i, last);
        return;
      end
    end
    finish_now("send_word_timeout");
  endtask

  task automatic send_frame(input int n, input bit pat, input bit gaps);
    logic [31:0] r, i;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      r = pat ? (32'(k) << 22) : $urandom;
      i = pat ? (32'd0 - (32'(k) << 22)) : $urandom;
      send_word(r, i, k == n - 1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_start(input int bound, output bit found);
    found = 1'b0;
    for (int w = 0; w < bound; w++) begin
      if (start) begin
        found = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_dd();
    dd_man = 1'b1;
    @(negedge clk);
    dd_man = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0] nwords;
    logic       exp_err;
    logic       exp_issue;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    finish_now("global_timeout");
  end

  initial begin
    bit found, held;
    int e0, s0, me0;

    vecs[0] = '{nwords: 8'd24, exp_err: 1'b0, exp_issue: 1'b1};
    vecs[1] = '{nwords: 8'd10, exp_err: 1'b1, exp_issue: 1'b0};
    vecs[2] = '{nwords: 8'd24, exp_err: 1'b0, exp_issue: 1'b1};
    vecs[3] = '{nwords: 8'd30, exp_err: 1'b1, exp_issue: 1'b0};
    vecs[4] = '{nwords: 8'd24, exp_err: 1'b0, exp_issue: 1'b1};
    vecs[5] = '{nwords: 8'd1,  exp_err: 1'b1, exp_issue: 1'b0};
    vecs[6] = '{nwords: 8'd25, exp_err: 1'b1, exp_issue: 1'b0};
    vecs[7] = '{nwords: 8'd23, exp_err: 1'b1, exp_issue: 1'b0};

    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data_r = '0; s_data_i = '0;
    dd_man = 1'b0; dd_rand_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready_first", 64'(s_ready), 64'd0);
    check("rst_outs", {start, H_in_valid, Y_in_valid, frame_err, frames_issued}, 64'd0);
    check("rst_data", {H_in_r, Y_in_i}, 64'd0);
    @(negedge clk);
    check("ready_after_rst", 64'(s_ready), 64'd1);

    // Single patterned frame with exact alignment.
    send_frame(24, 1'b1, 1'b0);
    check("wait_no_start", {62'd0, start, s_ready}, 64'd0);
    @(negedge clk);
    check("start_at_c2", 64'(start), 64'd1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("stream_h_r", 64'(H_in_r), 64'(32'(k) << 22));
      check("start_once", 64'(start), 64'd0);
    end
    @(negedge clk);
    check("fi_one", 64'(frames_issued), 64'd1);
    check("ready_t17", 64'(s_ready), 64'd1);

    // Second frame without a credit return is held in WAIT.
    send_frame(24, 1'b0, 1'b0);
    held = 1'b1;
    repeat (20) begin
      if (start || s_ready) held = 1'b0;
      @(negedge clk);
    end
    check("held_in_wait", 64'(held), 64'd1);
    pulse_dd();
    check("dd_start_d1", 64'(start), 64'd0);
    @(negedge clk);
    check("dd_start_d2", 64'(start), 64'd1);
    repeat (17) @(negedge clk);
    check("fi_two", 64'(frames_issued), 64'd2);
    pulse_dd();

    // Table of frame shapes: malformed ones raise frame_err and never issue.
    for (int v = 0; v < 8; v++) begin
      e0 = err_seen;
      s0 = starts;
      send_frame(int'(vecs[v].nwords), 1'b0, 1'b1);
      repeat (24) @(negedge clk);
      check($sformatf("vec%0d_err", v), 64'(err_seen - e0), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_issue", v), 64'(starts - s0), 64'(vecs[v].exp_issue));
      pulse_dd();
    end

    // Credit return in the consuming cycle leaves the credit set.
    send_frame(24, 1'b0, 1'b0);
    dd_man = 1'b1;
    @(negedge clk);
    dd_man = 1'b0;
    check("coincide_start", 64'(start), 64'd1);
    repeat (17) @(negedge clk);
    send_frame(24, 1'b0, 1'b0);
    wait_start(40, found);
    check("credit_kept", 64'(found), 64'd1);
    repeat (18) @(negedge clk);
    pulse_dd();

    // Randomized frames, gaps and credit returns against the model.
    e0  = err_seen;
    me0 = m_err;
    dd_rand_en = 1'b1;
    for (int f = 0; f < 16; f++) begin
      if ($urandom_range(0, 3) == 3) send_frame($urandom_range(1, 30), 1'b0, 1'b1);
      else send_frame(24, 1'b0, 1'b1);
    end
    found = 1'b0;
    for (int w = 0; w < 3000; w++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_active && !mon_fi_pend && s_ready) begin
        found = 1'b1;
        break;
      end
    end
    dd_rand_en = 1'b0;
    @(negedge clk);
    check("random_drained", 64'(found), 64'd1);
    check("random_errs", 64'(err_seen - e0), 64'(m_err - me0));
    pulse_dd();

    // Reset in the middle of a stream.
    send_frame(24, 1'b0, 1'b0);
    wait_start(40, found);
    check("pre_rst_start", 64'(found), 64'd1);
    repeat (6) @(negedge clk);
    check("pre_rst_streaming", 64'(H_in_valid), 64'd1);
    #2 rst = 1'b1;
    m_cnt  = 0;
    m_disc = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_ctrl", {start, H_in_valid, Y_in_valid, frame_err, s_ready, frames_issued}, 64'd0);
    check("rst_mid_data", {H_in_r, H_in_i}, 64'd0);
    check("rst_mid_ydata", {Y_in_r, Y_in_i}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(24, 1'b1, 1'b0);
    wait_start(40, found);
    check("post_rst_start", 64'(found), 64'd1);
    repeat (17) @(negedge clk);
    check("post_rst_fi", 64'(frames_issued), 64'd1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
